// File: rtl/priority_decoder_if.sv
// Beat-stream input and result-word output of the priority decoder.
// The slave modport is the decoder side; the master modport drives beats and accepts results.
interface priority_decoder_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic [WIDTH-1:0] data_i;
    logic             data_val_i;
    logic             data_last_i;
    logic             data_ready_o;
    logic [WIDTH-1:0] word_o;
    logic [CNT_W-1:0] count_o;
    logic             err_onehot_o;
    logic             err_dup_o;
    logic             err_order_o;
    logic             word_val_o;
    logic             word_ready_i;

    modport slave (
        input  data_i, data_val_i, data_last_i, word_ready_i,
        output data_ready_o, word_o, count_o, err_onehot_o, err_dup_o, err_order_o, word_val_o
    );

    modport master (
        output data_i, data_val_i, data_last_i, word_ready_i,
        input  data_ready_o, word_o, count_o, err_onehot_o, err_dup_o, err_order_o, word_val_o
    );
endinterface

// File: rtl/priority_decoder.sv
// Rebuilds a word from a packet of one-hot beats (LSB first). It counts the good beats,
// flags malformed, duplicate and out-of-order beats, and presents the result with valid/ready.
module priority_decoder #(
    parameter int WIDTH = 16
) (
    input  logic              clk_i,
    input  logic              srst_i,
    priority_decoder_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] OUTPUT  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, prev_q, prev_d, word_q, word_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, count_q, count_d;
    logic             acc_oh_q, acc_oh_d, acc_dup_q, acc_dup_d, acc_ord_q, acc_ord_d;
    logic             err_oh_q, err_oh_d, err_dup_q, err_dup_d, err_ord_q, err_ord_d;
    logic             accept, handshake, onehot, dup, order, good;

    always_comb begin
        accept    = (state_q == COLLECT) && bus.data_val_i;
        handshake = (state_q == OUTPUT) && bus.word_ready_i;
        // x & (x-1) clears the lowest set bit, so zero means at most one bit is set
        onehot    = (bus.data_i != '0) && ((bus.data_i & (bus.data_i - WIDTH'(1))) == '0);
        dup       = onehot && ((bus.data_i & acc_q) != '0);
        order     = onehot && !dup && (prev_q != '0) && (bus.data_i <= prev_q);
        good      = onehot && !dup;

        state_d   = state_q;
        acc_d     = acc_q;
        prev_d    = prev_q;
        cnt_d     = cnt_q;
        acc_oh_d  = acc_oh_q;
        acc_dup_d = acc_dup_q;
        acc_ord_d = acc_ord_q;
        word_d    = word_q;
        count_d   = count_q;
        err_oh_d  = err_oh_q;
        err_dup_d = err_dup_q;
        err_ord_d = err_ord_q;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    acc_d     = acc_q | bus.data_i;
                    acc_oh_d  = acc_oh_q | !onehot;
                    acc_dup_d = acc_dup_q | dup;
                    acc_ord_d = acc_ord_q | order;
                    if (good) begin
                        prev_d = bus.data_i;
                        if (cnt_q != CNT_W'(WIDTH)) cnt_d = cnt_q + CNT_W'(1);
                    end
                    // The result registers take the merged state including this last beat
                    if (bus.data_last_i) begin
                        state_d   = OUTPUT;
                        word_d    = acc_d;
                        count_d   = cnt_d;
                        err_oh_d  = acc_oh_d;
                        err_dup_d = acc_dup_d;
                        err_ord_d = acc_ord_d;
                    end
                end
            end
            default: begin
                if (handshake) begin
                    state_d   = COLLECT;
                    acc_d     = '0;
                    prev_d    = '0;
                    cnt_d     = '0;
                    acc_oh_d  = 1'b0;
                    acc_dup_d = 1'b0;
                    acc_ord_d = 1'b0;
                    word_d    = '0;
                    count_d   = '0;
                    err_oh_d  = 1'b0;
                    err_dup_d = 1'b0;
                    err_ord_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_q   <= COLLECT;
            acc_q     <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            acc_oh_q  <= 1'b0;
            acc_dup_q <= 1'b0;
            acc_ord_q <= 1'b0;
            word_q    <= '0;
            count_q   <= '0;
            err_oh_q  <= 1'b0;
            err_dup_q <= 1'b0;
            err_ord_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            acc_oh_q  <= acc_oh_d;
            acc_dup_q <= acc_dup_d;
            acc_ord_q <= acc_ord_d;
            word_q    <= word_d;
            count_q   <= count_d;
            err_oh_q  <= err_oh_d;
            err_dup_q <= err_dup_d;
            err_ord_q <= err_ord_d;
        end
    end

    assign bus.data_ready_o = (state_q == COLLECT);
    assign bus.word_val_o   = (state_q == OUTPUT);
    assign bus.word_o       = word_q;
    assign bus.count_o      = count_q;
    assign bus.err_onehot_o = err_oh_q;
    assign bus.err_dup_o    = err_dup_q;
    assign bus.err_order_o  = err_ord_q;
endmodule
